// File: rtl/reg_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// reg_wb_arbiter_pkg
// Shared widths, constants and types for the register file write-side front
// end. The address and data widths, the zero word, the write-enable level and
// the register count all live here so the arbiter and its queue never carry
// local literals.
// ----------------------------------------------------------------------------
package reg_wb_arbiter_pkg;

    localparam int RegAddrWidth = 5;
    localparam int RegDataWidth = 32;
    localparam int RegNum       = 32;

    typedef logic [RegAddrWidth-1:0] reg_addr_t;
    typedef logic [RegDataWidth-1:0] reg_data_t;

    localparam reg_data_t ZeroWord     = '0;
    localparam reg_addr_t ZeroReg      = '0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;

    // One queued MDU result: destination register plus the value to write.
    typedef struct packed {
        reg_addr_t des;
        reg_data_t data;
    } mdu_entry_t;

    // Which source owns the register file port in the next cycle.
    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_WB,
        GRANT_MDU
    } grant_e;

    // Register 0 is hardwired, so any write aimed at it is dropped.
    function automatic logic isWritable(input reg_addr_t addr);
        return addr != ZeroReg;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO that holds MDU results until the register file port
// is free. DEPTH must be a power of two so the pointers wrap naturally.
//
// Ports:
//   clk          clock, all state on posedge
//   rst          asynchronous active-high reset (empties the queue)
//   push_i       write push_data_i into the tail (ignored when full)
//   push_data_i  entry to enqueue
//   pop_i        drop the head entry (ignored when empty)
//   pop_data_o   current head entry
//   count_o      number of entries held
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
// ----------------------------------------------------------------------------
module wb_fifo
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(mdu_entry_t)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wrPtr_q;
    logic [PtrW-1:0]  rdPtr_q;
    logic [CntW-1:0]  count_q;
    logic             pushOk;
    logic             popOk;

    assign full_o     = (count_q == CntW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rdPtr_q];

    // Pop only looks at the state before the edge, so an entry pushed this
    // cycle can never be popped in the same cycle.
    assign pushOk = push_i && !full_o;
    assign popOk  = pop_i && !empty_o;

    // Pointers and occupancy; reset simply forgets whatever was queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: stale slots are unreachable once the pointers
    // are cleared.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// reg_wb_arbiter
// Owns the single register file write port and arbitrates between the
// in-order WRITE stage and the long-latency multiply/divide unit (MDU).
// WRITE stage requests always win; MDU results wait in wb_fifo and drain
// whenever the WRITE stage leaves the port idle. A starvation counter raises
// pipe_stall so the pipeline inserts a bubble and the queue head gets through.
//
// Optional feature macro: WB_SCOREBOARD_EN
//   defined   -> 32-bit destination scoreboard drives rs/rt/rd_busy
//   undefined -> no scoreboard, *_busy tied low, mdu_issue* ignored
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   wb_write_reg/wb_des/wb_data  WRITE stage write request
//   mdu_valid/mdu_des/mdu_data   MDU result, accepted when mdu_ready is high
//   mdu_ready                  queue can accept a result (low during rst)
//   mdu_issue/mdu_issue_des    ID dispatched an MDU op to this destination
//   rs, rt, rd                 ID query addresses
//   rs_busy, rt_busy, rd_busy  queried register has an MDU write outstanding
//   pipe_stall                 WRITE stage input must be a bubble next cycle
//   w_write_reg/reg_des/reg_data registered register file write port
// ----------------------------------------------------------------------------
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_write_reg,
    input  logic [RegAddrWidth-1:0] wb_des,
    input  logic [RegDataWidth-1:0] wb_data,
    input  logic                    mdu_valid,
    input  logic [RegAddrWidth-1:0] mdu_des,
    input  logic [RegDataWidth-1:0] mdu_data,
    output logic                    mdu_ready,
    input  logic                    mdu_issue,
    input  logic [RegAddrWidth-1:0] mdu_issue_des,
    input  logic [RegAddrWidth-1:0] rs,
    input  logic [RegAddrWidth-1:0] rt,
    input  logic [RegAddrWidth-1:0] rd,
    output logic                    rs_busy,
    output logic                    rt_busy,
    output logic                    rd_busy,
    output logic                    pipe_stall,
    output logic                    w_write_reg,
    output logic [RegAddrWidth-1:0] reg_des,
    output logic [RegDataWidth-1:0] reg_data
);

    localparam int CntW    = $clog2(FIFO_DEPTH) + 1;
    localparam int StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    logic            wbReq;
    logic            mduPush;
    logic            fifoPop;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [CntW-1:0] fifoCount;
    mdu_entry_t      pushEntry;
    mdu_entry_t      headEntry;
    grant_e          grant;

    logic              wWriteReg_q, wWriteReg_d;
    reg_addr_t         regDes_q,    regDes_d;
    reg_data_t         regData_q,   regData_d;
    logic [StarveW-1:0] starve_q,   starve_d;

    // A WRITE stage request to r0 counts as idle; an MDU result for r0
    // completes its handshake but is never queued.
    assign wbReq     = wb_write_reg && isWritable(wb_des);
    assign mdu_ready = !fifoFull && !rst;
    assign mduPush   = mdu_valid && mdu_ready && isWritable(mdu_des);
    assign pushEntry = '{des: mdu_des, data: mdu_data};
    assign fifoPop   = (grant == GRANT_MDU);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(mdu_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (mduPush),
        .push_data_i (pushEntry),
        .pop_i       (fifoPop),
        .pop_data_o  (headEntry),
        .count_o     (fifoCount),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    // Fixed priority: WRITE stage, then queue head, otherwise leave the port
    // idle. An idle grant keeps the last address and data on the port.
    always_comb begin
        grant       = GRANT_IDLE;
        wWriteReg_d = WriteDisable;
        regDes_d    = regDes_q;
        regData_d   = regData_q;
        if (wbReq) begin
            grant       = GRANT_WB;
            wWriteReg_d = WriteEnable;
            regDes_d    = wb_des;
            regData_d   = wb_data;
        end else if (!fifoEmpty) begin
            grant       = GRANT_MDU;
            wWriteReg_d = WriteEnable;
            regDes_d    = headEntry.des;
            regData_d   = headEntry.data;
        end
    end

    // Counts cycles the queue head is blocked by the WRITE stage. It only
    // resets when the head finally drains or the queue is empty, so the
    // saturated value holds pipe_stall until the bubble arrives.
    always_comb begin
        starve_d = starve_q;
        if (fifoEmpty || fifoPop) begin
            starve_d = '0;
        end else if (wbReq && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign pipe_stall = (starve_q == StarveMax);

    // Registered write port and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wWriteReg_q <= WriteDisable;
            regDes_q    <= ZeroReg;
            regData_q   <= ZeroWord;
            starve_q    <= '0;
        end else begin
            wWriteReg_q <= wWriteReg_d;
            regDes_q    <= regDes_d;
            regData_q   <= regData_d;
            starve_q    <= starve_d;
        end
    end

    assign w_write_reg = wWriteReg_q;
    assign reg_des     = regDes_q;
    assign reg_data    = regData_q;

`ifdef WB_SCOREBOARD_EN
    logic [RegNum-1:0] busy_q, busy_d;

    // A bit is set when ID issues to that register and cleared when its
    // queued result wins the port. Issue is applied last so that a set and
    // clear of the same register in one cycle leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (fifoPop) begin
            busy_d[headEntry.des] = 1'b0;
        end
        if (mdu_issue) begin
            busy_d[mdu_issue_des] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state; reset forgets all outstanding writes along with the
    // discarded queue entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs_busy = busy_q[rs];
    assign rt_busy = busy_q[rt];
    assign rd_busy = busy_q[rd];
`else
    logic unusedSb;

    // Without the scoreboard, software schedules around MDU latency and the
    // issue/query inputs have no effect.
    assign unusedSb = &{1'b0, mdu_issue, mdu_issue_des, rs, rt, rd};
    assign rs_busy  = 1'b0;
    assign rt_busy  = 1'b0;
    assign rd_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_wb_arbiter
// Directed bench for reg_wb_arbiter with FIFO_DEPTH=2, STARVE_LIMIT=4.
// Inputs change 1ns after a rising edge and outputs are sampled at that same
// point, so each step() observes the state latched by the edge just passed.
// ----------------------------------------------------------------------------
module tb_reg_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
    localparam logic SbEn = 1'b1;
`else
    localparam logic SbEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wb_write_reg;
    logic [4:0]  wb_des;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_des;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_des;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rs_busy;
    logic        rt_busy;
    logic        rd_busy;
    logic        pipe_stall;
    logic        w_write_reg;
    logic [4:0]  reg_des;
    logic [31:0] reg_data;

    int checks = 0;
    int errors = 0;

    reg_wb_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_write_reg  (wb_write_reg),
        .wb_des        (wb_des),
        .wb_data       (wb_data),
        .mdu_valid     (mdu_valid),
        .mdu_des       (mdu_des),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .mdu_issue     (mdu_issue),
        .mdu_issue_des (mdu_issue_des),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .rd_busy       (rd_busy),
        .pipe_stall    (pipe_stall),
        .w_write_reg   (w_write_reg),
        .reg_des       (reg_des),
        .reg_data      (reg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the WRITE stage and MDU result inputs for the coming edge.
    task automatic applyStimulus(input logic wbW, input logic [4:0] wbD,
                                 input logic [31:0] wbV, input logic mV,
                                 input logic [4:0] mD, input logic [31:0] mVal);
        wb_write_reg = wbW;
        wb_des       = wbD;
        wb_data      = wbV;
        mdu_valid    = mV;
        mdu_des      = mD;
        mdu_data     = mVal;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Port check shorthand for the three write port outputs.
    task automatic checkPort(input string tag, input logic we,
                             input logic [4:0] des, input logic [31:0] data);
        checkOutput({tag, "_we"},   32'(w_write_reg), 32'(we));
        checkOutput({tag, "_des"},  32'(reg_des),     32'(des));
        checkOutput({tag, "_data"}, reg_data,         data);
    endtask

    initial begin
        rst           = 1'b1;
        mdu_issue     = 1'b0;
        mdu_issue_des = 5'd0;
        rs            = 5'd0;
        rt            = 5'd0;
        rd            = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;

        // Reset state
        checkPort("rst", 1'b0, 5'd0, 32'h0);
        checkOutput("rst_ready", 32'(mdu_ready), 32'd0);
        checkOutput("rst_stall", 32'(pipe_stall), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(mdu_ready), 32'd1);

        // WRITE stage r5 = 0x1234, visible the next cycle, then idle holds
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkPort("wb_r5", 1'b1, 5'd5, 32'h1234);
        step();
        checkPort("idle_hold", 1'b0, 5'd5, 32'h1234);

        // MDU r7 = 0xDEAD with scoreboard tracking
        mdu_issue     = 1'b1;
        mdu_issue_des = 5'd7;
        rd            = 5'd7;
        step();
        mdu_issue = 1'b0;
        checkOutput("r7_busy_issued", 32'(rd_busy), 32'(SbEn));
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("r7_not_yet", 32'(w_write_reg), 32'd0);
        checkOutput("r7_busy_queued", 32'(rd_busy), 32'(SbEn));
        step();
        checkPort("mdu_r7", 1'b1, 5'd7, 32'hDEAD);
        checkOutput("r7_busy_clear", 32'(rd_busy), 32'd0);

        // Starvation: WRITE stage busy, one queued entry r9
        applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'hBEEF);
        step();
        applyStimulus(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'h0);
        checkOutput("starve_c0", 32'(pipe_stall), 32'd0);
        checkPort("starve_wb0", 1'b1, 5'd1, 32'h100);
        for (int i = 1; i <= 4; i++) begin
            step();
            checkOutput($sformatf("starve_c%0d", i), 32'(pipe_stall), 32'(i == 4));
        end
        step();
        checkOutput("starve_sat", 32'(pipe_stall), 32'd1);
        checkPort("starve_wb_last", 1'b1, 5'd1, 32'h101);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        checkPort("starve_drain", 1'b1, 5'd9, 32'hBEEF);
        checkOutput("starve_clear", 32'(pipe_stall), 32'd0);

        // Three MDU results into a 2-deep queue, WRITE stage busy
        applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd10, 32'hA0);
        checkOutput("fill_ready0", 32'(mdu_ready), 32'd1);
        step();
        applyStimulus(1'b1, 5'd2, 32'h201, 1'b1, 5'd11, 32'hA1);
        checkOutput("fill_ready1", 32'(mdu_ready), 32'd1);
        step();
        applyStimulus(1'b1, 5'd2, 32'h202, 1'b1, 5'd12, 32'hA2);
        checkOutput("fill_full", 32'(mdu_ready), 32'd0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hA2);
        checkOutput("fill_still_full", 32'(mdu_ready), 32'd0);
        step();
        checkOutput("fill_reopen", 32'(mdu_ready), 32'd1);
        checkPort("fill_pop_a", 1'b1, 5'd10, 32'hA0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkPort("fill_pop_b", 1'b1, 5'd11, 32'hA1);
        step();
        checkPort("fill_pop_c", 1'b1, 5'd12, 32'hA2);
        step();
        checkOutput("fill_done", 32'(w_write_reg), 32'd0);

        // Writes aimed at r0 from either source are dropped
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
        step();
        checkPort("r0_c1", 1'b0, 5'd12, 32'hA2);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkPort("r0_c2", 1'b0, 5'd12, 32'hA2);
        checkOutput("r0_ready", 32'(mdu_ready), 32'd1);
        step();
        checkOutput("r0_c3", 32'(w_write_reg), 32'd0);

        // Reset mid-drain with two queued entries and three busy bits
        rs = 5'd3;
        rt = 5'd4;
        rd = 5'd6;
        applyStimulus(1'b1, 5'd1, 32'h300, 1'b0, 5'd0, 32'h0);
        mdu_issue     = 1'b1;
        mdu_issue_des = 5'd3;
        step();
        applyStimulus(1'b1, 5'd1, 32'h301, 1'b1, 5'd3, 32'h33);
        mdu_issue_des = 5'd4;
        step();
        applyStimulus(1'b1, 5'd1, 32'h302, 1'b1, 5'd4, 32'h44);
        mdu_issue_des = 5'd6;
        step();
        applyStimulus(1'b1, 5'd1, 32'h303, 1'b0, 5'd0, 32'h0);
        mdu_issue = 1'b0;
        checkOutput("pre_rst_rs", 32'(rs_busy), 32'(SbEn));
        checkOutput("pre_rst_rt", 32'(rt_busy), 32'(SbEn));
        checkOutput("pre_rst_rd", 32'(rd_busy), 32'(SbEn));
        checkOutput("pre_rst_full", 32'(mdu_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkPort("mid_rst", 1'b0, 5'd0, 32'h0);
        checkOutput("mid_rst_ready", 32'(mdu_ready), 32'd0);
        checkOutput("mid_rst_busy", 32'({rs_busy, rt_busy, rd_busy}), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("after_rst_ready", 32'(mdu_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("after_rst_we%0d", i), 32'(w_write_reg), 32'd0);
        end
        checkOutput("after_rst_busy", 32'({rs_busy, rt_busy, rd_busy}), 32'd0);
        checkOutput("after_rst_stall", 32'(pipe_stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
